// File: rtl/unified_cache_1024_words.sv
// Direct-mapped, write-through unified cache (one word per line) with RAM
// fetch/flush handshakes. Every write is forwarded to RAM; misses fetch one word.
module unified_cache_1024_words #(
  parameter int WORDS      = 1024,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [0:0]            wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  fetch_ack,
  input  logic                  flush_ack,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  flush,
  output logic                  fetch,
  output logic                  hit
);

  // state | meaning
  // IDLE  | lookup or write on every edge
  // FLUSH | write forwarded to RAM, waiting for flush_ack
  // FETCH | miss outstanding, waiting for fetch_ack with data on dina
  localparam int IDX_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, FLUSH, FETCH} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   data_mem [WORDS];
  logic [TAG_W-1:0]        tag_mem  [WORDS];
  logic [WORDS-1:0]        valid;
  logic [IDX_W-1:0]        lat_idx;
  logic [TAG_W-1:0]        lat_tag;

  logic [IDX_W-1:0]        addr_idx;
  logic [TAG_W-1:0]        addr_tag;
  logic                    lookup_hit;

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [TAG_W-1:0]        mem_tag;

  assign addr_idx   = addra[IDX_W-1:0];
  assign addr_tag   = addra[ADDR_WIDTH-1:IDX_W];
  assign lookup_hit = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  // Arrays carry no reset; validity is tracked solely by the valid flops.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = addr_idx;
    mem_tag = addr_tag;
    if (!rsta) begin
      case (state)
        IDLE:    mem_we = wea[0];
        FETCH: begin
          mem_we  = fetch_ack;
          mem_idx = lat_idx;
          mem_tag = lat_tag;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (mem_we) begin
      data_mem[mem_idx] <= dina;
      tag_mem[mem_idx]  <= mem_tag;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state   <= IDLE;
      valid   <= '0;
      douta   <= '0;
      hit     <= 1'b0;
      fetch   <= 1'b0;
      flush   <= 1'b0;
      lat_idx <= '0;
      lat_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wea[0]) begin
            valid[addr_idx] <= 1'b1;
            lat_idx         <= addr_idx;
            lat_tag         <= addr_tag;
            douta           <= dina;
            flush           <= 1'b1;
            hit             <= 1'b0;
            state           <= FLUSH;
          end else if (lookup_hit) begin
            douta <= data_mem[addr_idx];
            hit   <= 1'b1;
            fetch <= 1'b0;
          end else begin
            lat_idx <= addr_idx;
            lat_tag <= addr_tag;
            fetch   <= 1'b1;
            hit     <= 1'b0;
            state   <= FETCH;
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            flush <= 1'b0;
            state <= IDLE;
          end
        end
        FETCH: begin
          if (fetch_ack) begin
            valid[lat_idx] <= 1'b1;
            douta          <= dina;
            fetch          <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_cache_1024_words.sv
// Directed bench for unified_cache_1024_words: writes, misses, hits, index
// conflicts, reset mid-handshake and stray acks, against hand-computed values.
module tb_unified_cache_1024_words;

  logic        clka = 1'b0;
  logic        rsta;
  logic [0:0]  wea;
  logic [11:0] addra;
  logic [31:0] dina;
  logic        fetch_ack;
  logic        flush_ack;
  logic [31:0] douta;
  logic        flush;
  logic        fetch;
  logic        hit;

  int checks = 0;
  int failures = 0;

  unified_cache_1024_words #(1024, 12, 32) dut (
    .clka      (clka),
    .rsta      (rsta),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .fetch_ack (fetch_ack),
    .flush_ack (flush_ack),
    .douta     (douta),
    .flush     (flush),
    .fetch     (fetch),
    .hit       (hit)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clka);
      @(negedge clka);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] d, input logic h,
                            input logic fe, input logic fl);
    check_eq({tag, ".douta"}, douta, d);
    check_eq({tag, ".hit"},   {31'd0, hit},   {31'd0, h});
    check_eq({tag, ".fetch"}, {31'd0, fetch}, {31'd0, fe});
    check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
  endtask

  initial begin
    rsta = 1'b1; wea = 1'b0; addra = '0; dina = '0; fetch_ack = 1'b0; flush_ack = 1'b0;
    @(negedge clka);
    tick(2);
    check_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rsta = 1'b0;

    // 1: write then read at address 0
    addra = 12'd0; dina = 32'd2123000123; wea = 1'b1;
    tick();
    check_outs("wr0", 32'd2123000123, 1'b0, 1'b0, 1'b1);
    wea = 1'b0; dina = 32'd0;
    tick(9);
    check_eq("wr0_hold.flush", {31'd0, flush}, 32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check_outs("wr0_ack", 32'd2123000123, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rd0_hit", 32'd2123000123, 1'b1, 1'b0, 1'b0);

    // 2: read miss at 1000
    addra = 12'd1000;
    tick();
    check_outs("miss1000", 32'd2123000123, 1'b0, 1'b1, 1'b0);
    tick(9);
    check_eq("miss1000_hold.fetch", {31'd0, fetch}, 32'd1);
    dina = 32'd1002003009; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0; dina = 32'd0;
    check_outs("fill1000", 32'd1002003009, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("hit1000", 32'd1002003009, 1'b1, 1'b0, 1'b0);

    // 3: read hit back at 0
    addra = 12'd0;
    tick();
    check_outs("hit0", 32'd2123000123, 1'b1, 1'b0, 1'b0);

    // 4: conflict write at 1024; ack held two cycles must not retrigger
    addra = 12'd1024; dina = 32'd998; wea = 1'b1;
    tick();
    wea = 1'b0;
    check_outs("wr1024", 32'd998, 1'b0, 1'b0, 1'b1);
    flush_ack = 1'b1;
    tick();
    check_outs("wr1024_ack", 32'd998, 1'b0, 1'b0, 1'b0);
    tick();
    flush_ack = 1'b0;
    check_outs("hit1024", 32'd998, 1'b1, 1'b0, 1'b0);

    // 5: conflict read at 0 misses; flush_ack in FETCH is ignored
    addra = 12'd0;
    tick();
    check_outs("miss0", 32'd998, 1'b0, 1'b1, 1'b0);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check_outs("fetch_flushack", 32'd998, 1'b0, 1'b1, 1'b0);
    dina = 32'd55; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check_outs("fill0", 32'd55, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("hit0b", 32'd55, 1'b1, 1'b0, 1'b0);

    // 6: reset during FETCH
    addra = 12'd2000;
    tick();
    check_outs("miss2000", 32'd55, 1'b0, 1'b1, 1'b0);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    check_outs("rst_fetch", 32'd0, 1'b0, 1'b0, 1'b0);
    addra = 12'd1000;
    tick();
    check_outs("miss1000_after_rst", 32'd0, 1'b0, 1'b1, 1'b0);
    dina = 32'd77; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check_outs("fill1000b", 32'd77, 1'b0, 1'b0, 1'b0);

    // reset during FLUSH
    addra = 12'd5; dina = 32'd9; wea = 1'b1;
    tick();
    wea = 1'b0;
    check_outs("wr5", 32'd9, 1'b0, 1'b0, 1'b1);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    check_outs("rst_flush", 32'd0, 1'b0, 1'b0, 1'b0);

    // stray acks while hitting in IDLE change nothing
    addra = 12'd7; dina = 32'h1234; wea = 1'b1;
    tick();
    wea = 1'b0;
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    tick();
    check_outs("hit7", 32'h1234, 1'b1, 1'b0, 1'b0);
    dina = 32'hdead; fetch_ack = 1'b1; flush_ack = 1'b1;
    tick();
    fetch_ack = 1'b0; flush_ack = 1'b0;
    check_outs("stray_acks", 32'h1234, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
